gf_poly_scale_subtract: RTL and testbench
=========================================

Name: gf_poly_scale_subtract

Overview:
Sequencer that sits directly upstream of the GF(2^8) remainder multiplier in the Euclid/division datapath of the RS(255,k) decoder. It performs one polynomial long-division step, Rm(x) ^= scale · D(x) · x^shift. For each coefficient it feeds divisor coefficient and scale factor to the multiplier, waits for the multiplier's done, and XORs the product back into the remainder buffer. It owns the divisor and remainder coefficient buffers and exposes load/readback ports to the division controller.

Parameters:
NCOEF, 17, number of coefficient slots in each of the D and Rm buffers (2t+1 for t=8)
IDX_W, 5, width of coefficient index, degree and shift fields
TIMEOUT, 15, max cycles spent in DRIVE waiting for mult_done before err is raised

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
load_en  in  1  write strobe for the coefficient buffers (ignored while busy)
load_sel  in  1  0 = write D buffer, 1 = write Rm buffer
load_addr  in  IDX_W  coefficient index; writes with addr >= NCOEF are dropped
load_data  in  8  coefficient value
start  in  1  begin one scale-subtract step (sampled only in IDLE)
scale  in  8  multiplier factor (leading quotient coefficient), latched at start
shift  in  IDX_W  destination offset into Rm, latched at start
div_deg  in  IDX_W  degree of D(x), latched at start
rd_addr  in  IDX_W  readback index into Rm
rd_data  out  8  Rm[rd_addr], combinational; 0 if rd_addr >= NCOEF
mult_a  out  8  D[idx] to multiplier input a
mult_b  out  8  latched scale to multiplier input b
polynomial_compute  out  1  high whenever the FSM is not IDLE
coef_ready_flag  out  1  operand-valid to multiplier, high only in DRIVE
mult_product  in  8  multiplier product (R_out)
mult_done  in  1  multiplier done (GF1_multiply_done)
busy  out  1  high in all states except IDLE
step_done  out  1  one-cycle pulse on step completion
err  out  1  sticky error; cleared by reset or the next accepted start

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE; D and Rm all 0x00; idx=0; wait counter=0.
- Reset values of outputs: mult_a=mult_b=0x00, coef_ready_flag=0, polynomial_compute=0, busy=0, step_done=0, err=0.
- Reset mid-step aborts the step with no further Rm update.
- Field is GF(2^8) with polynomial 0x11D. Addition is XOR. No other arithmetic is performed locally.
- IDLE:
  - load_en writes buffer[load_sel][load_addr].
  - If start=1: latch scale, shift and div_deg, clear err.
  - If div_deg+shift > NCOEF-1, or div_deg > NCOEF-1: set err, pulse step_done next cycle, leave Rm untouched, stay IDLE.
  - Otherwise set idx=0 and go to DRIVE.
  - If start and load_en are high in the same cycle, the load is performed first and is visible to the step.
- DRIVE:
  - Outputs: coef_ready_flag=1, mult_a=D[idx], mult_b=scale.
  - mult_done is ignored in the first DRIVE cycle (stale-done guard).
  - From the second cycle on, if mult_done=1 at the edge: Rm[idx+shift] ^= mult_product, go to GAP.
  - Each cycle without done increments the wait counter. If it reaches TIMEOUT: set err, go to FIN, and leave Rm[idx+shift] unmodified.
- GAP (1 cycle):
  - coef_ready_flag=0, so the multiplier's done drops.
  - If idx == latched div_deg, go to FIN; else idx++ and go to DRIVE, with the wait counter reset.
- FIN: step_done=1 for exactly one cycle, then go to IDLE.
- start while busy and load_en while busy are ignored; buffers are not changed by loads.
- Latency: with a multiplier whose done is registered one cycle after coef_ready_flag, each coefficient takes 3 cycles. step_done asserts 3*(div_deg+1)+1 cycles after the start edge, and busy is high for that whole span.
- rd_data always reflects the current Rm contents, including mid-step.

Test Plan:
- Load D={0x03,0x01}, Rm={0x06,0x02}; start scale=0x02 shift=0 div_deg=1 -> step_done exactly 7 cycles after start; Rm[0]=0x00, Rm[1]=0x00; err=0.
- Load D[0]=0x80, Rm all 0; start scale=0x02 shift=3 div_deg=0 -> Rm[3]=0x1D, all other Rm=0x00, step_done 4 cycles after start.
- start with div_deg=10 shift=7 (NCOEF=17) -> err=1, step_done pulse next cycle, busy never rises, Rm unchanged.
- Hold mult_done=0 during DRIVE -> err=1 after 15 DRIVE cycles, step_done pulses, Rm unchanged; next valid start clears err.
- Assert reset in the second DRIVE cycle of a div_deg=3 step -> next cycle busy=0, coef_ready_flag=0, all Rm read as 0x00.
- Pulse start and load_en while busy -> neither has any effect; final Rm matches the first step's expected values.

Source files
------------

// File: rtl/gf_poly_scale_subtract.sv
`default_nettype none
// ============================================================================
// Module  : gf_poly_scale_subtract
// Brief   : One GF(2^8) long-division step Rm(x) ^= scale*D(x)*x^shift,
//           sequenced through an external multiplier.
// Revision: 1.0 - initial release
// ============================================================================
module gf_poly_scale_subtract #(
    parameter int NCOEF   = 17,
    parameter int IDX_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic             load_sel,
    input  logic [IDX_W-1:0] load_addr,
    input  logic [7:0]       load_data,
    input  logic             start,
    input  logic [7:0]       scale,
    input  logic [IDX_W-1:0] shift,
    input  logic [IDX_W-1:0] div_deg,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    output logic [7:0]       mult_a,
    output logic [7:0]       mult_b,
    output logic             polynomial_compute,
    output logic             coef_ready_flag,
    input  logic [7:0]       mult_product,
    input  logic             mult_done,
    output logic             busy,
    output logic             step_done,
    output logic             err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;
    localparam logic [1:0] c_FIN   = 2'd3;

    localparam int                    c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]        c_NCOEF     = (IDX_W + 1)'(NCOEF);
    localparam logic [IDX_W:0]        c_LAST      = (IDX_W + 1)'(NCOEF - 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [7:0]          r_d  [NCOEF];
    logic [7:0]          r_rm [NCOEF];
    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_shift;
    logic [IDX_W-1:0]    r_deg;
    logic [7:0]          r_scale;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_step_done;
    logic                r_err;

    logic [IDX_W-1:0]    w_dst;
    logic [IDX_W:0]      w_end;
    logic                w_bad;
    logic                w_load_ok;
    logic                w_rd_ok;

    assign w_dst     = r_idx + r_shift;
    assign w_end     = {1'b0, div_deg} + {1'b0, shift};
    assign w_bad     = (w_end > c_LAST) || ({1'b0, div_deg} > c_LAST);
    assign w_load_ok = ({1'b0, load_addr} < c_NCOEF);
    assign w_rd_ok   = ({1'b0, rd_addr} < c_NCOEF);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NCOEF; i++) begin
                r_d[i]  <= 8'h00;
                r_rm[i] <= 8'h00;
            end
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_shift     <= '0;
            r_deg       <= '0;
            r_scale     <= 8'h00;
            r_wait      <= '0;
            r_step_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (load_en && w_load_ok) begin
                        if (load_sel) r_rm[load_addr] <= load_data;
                        else          r_d[load_addr]  <= load_data;
                    end
                    if (start) begin
                        r_scale <= scale;
                        r_shift <= shift;
                        r_deg   <= div_deg;
                        r_idx   <= '0;
                        r_wait  <= '0;
                        r_err   <= 1'b0;
                        if (w_bad) begin
                            r_err       <= 1'b1;
                            r_step_done <= 1'b1;
                        end else begin
                            r_state <= c_DRIVE;
                        end
                    end
                end
                c_DRIVE: begin
                    // r_wait==0 marks the first DRIVE cycle, where a done left over
                    // from the previous coefficient must not be trusted.
                    if ((r_wait != '0) && mult_done) begin
                        r_rm[w_dst] <= r_rm[w_dst] ^ mult_product;
                        r_state     <= c_GAP;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_err       <= 1'b1;
                        r_step_done <= 1'b1;
                        r_state     <= c_FIN;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                c_GAP: begin
                    r_wait <= '0;
                    if (r_idx == r_deg) begin
                        r_step_done <= 1'b1;
                        r_state     <= c_FIN;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= c_DRIVE;
                    end
                end
                c_FIN:   r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign coef_ready_flag    = (r_state == c_DRIVE);
    assign mult_a             = coef_ready_flag ? r_d[r_idx] : 8'h00;
    assign mult_b             = coef_ready_flag ? r_scale : 8'h00;
    assign busy               = (r_state != c_IDLE);
    assign polynomial_compute = busy;
    assign step_done          = r_step_done;
    assign err                = r_err;
    assign rd_data            = w_rd_ok ? r_rm[rd_addr] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_gf_poly_scale_subtract.sv
`default_nettype none
// ============================================================================
// Module  : tb_gf_poly_scale_subtract
// Brief   : Scoreboard bench for gf_poly_scale_subtract with a GF multiplier model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gf_poly_scale_subtract;

    localparam int NC = 17;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load_en = 1'b0;
    logic       load_sel = 1'b0;
    logic [4:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       start = 1'b0;
    logic [7:0] scale = '0;
    logic [4:0] shift = '0;
    logic [4:0] div_deg = '0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data, mult_a, mult_b;
    logic       polynomial_compute, coef_ready_flag, busy, step_done, err;
    logic [7:0] mult_product;
    logic       mult_done;
    logic       hold_done = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    int         last_drv;
    logic [7:0] m_d  [NC];
    logic [7:0] m_rm [NC];
    logic [7:0] exp_q[$];

    gf_poly_scale_subtract dut (
        .clock(clock), .reset(reset), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .start(start), .scale(scale),
        .shift(shift), .div_deg(div_deg), .rd_addr(rd_addr), .rd_data(rd_data),
        .mult_a(mult_a), .mult_b(mult_b), .polynomial_compute(polynomial_compute),
        .coef_ready_flag(coef_ready_flag), .mult_product(mult_product),
        .mult_done(mult_done), .busy(busy), .step_done(step_done), .err(err)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
        end
        return p;
    endfunction

    // Multiplier stand-in: done and product registered one cycle after operands.
    always @(posedge clock) begin
        if (reset) begin
            mult_done    <= 1'b0;
            mult_product <= 8'h00;
        end else begin
            mult_done    <= coef_ready_flag && !hold_done;
            mult_product <= gfmul(mult_a, mult_b);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < NC; i++) begin
            m_d[i]  = 8'h00;
            m_rm[i] = 8'h00;
        end
    endtask

    task automatic load(input logic sel, input logic [4:0] addr, input logic [7:0] data);
        load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
        tick();
        load_en = 1'b0;
        if (addr < NC) begin
            if (sel) m_rm[addr] = data;
            else     m_d[addr]  = data;
        end
    endtask

    task automatic push_rm();
        for (int i = 0; i < NC; i++) exp_q.push_back(m_rm[i]);
    endtask

    task automatic check_rm(input string name);
        logic [7:0] e;
        for (int i = 0; i < NC; i++) begin
            rd_addr = i[4:0];
            #1;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s Rm[%0d]: scoreboard empty, got %h", name, i, rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL %s Rm[%0d]: got %h expected %h", name, i, rd_data, e);
                end
            end
        end
    endtask

    task automatic run_step(input logic [7:0] sc, input logic [4:0] sh, input logic [4:0] dg,
                            input int exp_lat, input logic exp_err, input string name);
        logic bad;
        logic [20:0] got, want;
        int cnt;
        bad = (int'(dg) + int'(sh) > NC - 1);
        want = bad ? 21'd0 : {1'b1, 1'b1, 1'b1, m_d[0], sc};
        if (!bad && !hold_done)
            for (int i = 0; i <= int'(dg); i++) m_rm[i + int'(sh)] ^= gfmul(m_d[i], sc);
        push_rm();
        scale = sc; shift = sh; div_deg = dg; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 1;
        last_drv = 0;
        got = {busy, polynomial_compute, coef_ready_flag, mult_a, mult_b};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s first_cycle: got %h expected %h", name, got, want);
        end
        while (1) begin
            if (coef_ready_flag === 1'b1) last_drv++;
            if (step_done === 1'b1 || cnt >= 200) break;
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, cnt, exp_lat);
        end
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b expected %b", name, err, exp_err);
        end
        check_rm(name);
        tick();
        n_checks++;
        if ({step_done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s after_pulse step_done/busy: got %b expected 00", name, {step_done, busy});
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy, polynomial_compute, coef_ready_flag, step_done, err, mult_a, mult_b} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {busy, polynomial_compute, coef_ready_flag, step_done, err, mult_a, mult_b});
        end
        push_rm();
        check_rm("reset_rm");
        rd_addr = 5'd20;
        #1;
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rd_out_of_range: got %h expected 00", rd_data);
        end
    endtask

    task automatic test_basic();
        do_reset();
        load(1'b0, 5'd0, 8'h03);
        load(1'b0, 5'd1, 8'h01);
        load(1'b1, 5'd0, 8'h06);
        load(1'b1, 5'd1, 8'h02);
        load(1'b1, 5'd25, 8'h77);
        run_step(8'h02, 5'd0, 5'd1, 7, 1'b0, "basic");
    endtask

    task automatic test_shift();
        do_reset();
        load(1'b0, 5'd0, 8'h80);
        run_step(8'h02, 5'd3, 5'd0, 4, 1'b0, "shift");
        rd_addr = 5'd3;
        #1;
        n_checks++;
        if (rd_data !== 8'h1D) begin
            n_fail++;
            $display("FAIL shift_reduce Rm[3]: got %h expected 1d", rd_data);
        end
    endtask

    task automatic test_range_err();
        do_reset();
        load(1'b1, 5'd16, 8'h5A);
        load(1'b0, 5'd0, 8'h11);
        run_step(8'h09, 5'd7, 5'd10, 1, 1'b1, "range_err");
    endtask

    task automatic test_timeout();
        do_reset();
        load(1'b0, 5'd0, 8'h22);
        load(1'b1, 5'd0, 8'h44);
        hold_done = 1'b1;
        run_step(8'h03, 5'd0, 5'd0, 16, 1'b1, "timeout");
        n_checks++;
        if (last_drv !== 15) begin
            n_fail++;
            $display("FAIL timeout_drive_cycles: got %0d expected 15", last_drv);
        end
        hold_done = 1'b0;
        run_step(8'h07, 5'd0, 5'd0, 4, 1'b0, "after_timeout");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load(1'b0, i[4:0], 8'(i + 1));
            load(1'b1, i[4:0], 8'(8'h11 * (i + 1)));
        end
        scale = 8'h05; shift = 5'd0; div_deg = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({busy, coef_ready_flag} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid busy/coef_ready: got %b expected 00", {busy, coef_ready_flag});
        end
        reset = 1'b0;
        for (int i = 0; i < NC; i++) begin
            m_d[i]  = 8'h00;
            m_rm[i] = 8'h00;
        end
        push_rm();
        check_rm("reset_mid");
    endtask

    task automatic test_back_to_back();
        int cnt;
        do_reset();
        load(1'b0, 5'd0, 8'h03);
        load(1'b0, 5'd1, 8'h01);
        load(1'b1, 5'd0, 8'h06);
        load(1'b1, 5'd1, 8'h02);
        m_rm[0] ^= gfmul(8'h03, 8'h02);
        m_rm[1] ^= gfmul(8'h01, 8'h02);
        push_rm();
        scale = 8'h02; shift = 5'd0; div_deg = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 1;
        while (step_done !== 1'b1 && cnt < 200) begin
            if (cnt == 2) begin
                start = 1'b1; scale = 8'hFF; shift = 5'd5; div_deg = 5'd2;
                load_en = 1'b1; load_sel = 1'b1; load_addr = 5'd0; load_data = 8'hAA;
            end else if (cnt == 4) begin
                load_sel = 1'b0; load_addr = 5'd1; load_data = 8'h55;
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
            tick();
            cnt++;
        end
        start = 1'b0; load_en = 1'b0;
        n_checks++;
        if (cnt !== 7) begin
            n_fail++;
            $display("FAIL busy_ignore latency: got %0d expected 7", cnt);
        end
        check_rm("busy_ignore");
        tick();
        load(1'b0, 5'd2, 8'h9C);
        load(1'b0, 5'd1, 8'h47);
        run_step(8'h35, 5'd14, 5'd2, 10, 1'b0, "b2b_edge");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_range_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
